// File: rtl/iter_alu.sv
// iter_alu: one-hot ALU with iterative unsigned multiply/divide.
// Base ops complete one cycle after acceptance. MUL/MULHU/DIVU/REMU
// iterate WIDTH steps on a shared 2*WIDTH working register. Results are
// held in y while out_valid is high, until the consumer takes them.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SH_W = $clog2(WIDTH);

  // Iterative op codes kept in op_r; bit 1 distinguishes divide from multiply.
  localparam logic [1:0] OP_MUL   = 2'd0;
  localparam logic [1:0] OP_MULHU = 2'd1;
  localparam logic [1:0] OP_DIVU  = 2'd2;
  localparam logic [1:0] OP_REMU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [WIDTH-1:0]   y_r, y_s;
  logic [WIDTH-1:0]   opb_r, opb_s;
  logic [2*WIDTH-1:0] prod_r, prod_s;
  logic [SH_W-1:0]    cnt_r, cnt_s;
  logic [1:0]         op_r, op_s;

  logic               accept_s;
  logic               sub_s;
  logic [WIDTH-1:0]   b_eff_s;
  logic [WIDTH-1:0]   sum_s;
  logic               carry_s;
  logic               ovf_s;
  logic [WIDTH-1:0]   base_s;
  logic               is_iter_s;
  logic [1:0]         iter_op_s;
  logic               div0_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     rem_sh_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_diff_s;
  logic [2*WIDTH-1:0] step_s;
  logic [WIDTH-1:0]   iter_res_s;

  assign in_ready  = (state_r == IDLE) || ((state_r == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == DONE);
  assign y         = y_r;

  // Shared adder: SUB, SLTU and SLT all evaluate a + ~b + 1.
  always_comb begin
    sub_s              = f[1] | f[2] | f[3];
    b_eff_s            = sub_s ? ~b : b;
    {carry_s, sum_s}   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
    ovf_s              = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
  end

  // Single-cycle result; any f that is not exactly one base-op bit yields zero.
  always_comb begin
    base_s = {WIDTH{1'b0}};
    case (f)
      16'h0001: base_s = sum_s;
      16'h0002: base_s = sum_s;
      16'h0004: base_s = {{(WIDTH-1){1'b0}}, ~carry_s};
      16'h0008: base_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
      16'h0010: base_s = a & b;
      16'h0020: base_s = a | b;
      16'h0040: base_s = ~(a | b);
      16'h0080: base_s = a ^ b;
      16'h0100: base_s = a << b[SH_W-1:0];
      16'h0200: base_s = a >> b[SH_W-1:0];
      16'h0400: base_s = $signed(a) >>> b[SH_W-1:0];
      16'h0800: base_s = b;
      default:  base_s = {WIDTH{1'b0}};
    endcase
  end

  // Recognise the four iterative ops and the divide-by-zero shortcut.
  always_comb begin
    is_iter_s = 1'b0;
    iter_op_s = OP_MUL;
    case (f)
      16'h1000: begin is_iter_s = 1'b1; iter_op_s = OP_MUL;   end
      16'h2000: begin is_iter_s = 1'b1; iter_op_s = OP_MULHU; end
      16'h4000: begin is_iter_s = 1'b1; iter_op_s = OP_DIVU;  end
      16'h8000: begin is_iter_s = 1'b1; iter_op_s = OP_REMU;  end
      default:  begin is_iter_s = 1'b0; iter_op_s = OP_MUL;   end
    endcase
    div0_s = is_iter_s && iter_op_s[1] && (b == {WIDTH{1'b0}});
  end

  // One iteration step. Multiply: prod = {acc, multiplier}, add-then-shift-right.
  // Divide: prod = {remainder, dividend/quotient}, shift-left-then-trial-subtract.
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                 (prod_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    rem_sh_s   = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
    div_ge_s   = (rem_sh_s >= {1'b0, opb_r});
    // Only used when rem_sh_s >= divisor, so the difference fits in WIDTH bits.
    div_diff_s = rem_sh_s[WIDTH-1:0] - opb_r;
    if (op_r[1]) begin
      if (div_ge_s) begin
        step_s = {div_diff_s, prod_r[WIDTH-2:0], 1'b1};
      end else begin
        step_s = {rem_sh_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, prod_r[WIDTH-1:1]};
    end
  end

  // Pick the wanted half of the working register after the final step.
  always_comb begin
    case (op_r)
      OP_MUL:   iter_res_s = step_s[WIDTH-1:0];
      OP_MULHU: iter_res_s = step_s[2*WIDTH-1:WIDTH];
      OP_DIVU:  iter_res_s = step_s[WIDTH-1:0];
      OP_REMU:  iter_res_s = step_s[2*WIDTH-1:WIDTH];
      default:  iter_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-state and datapath-load logic for the IDLE/CALC/DONE controller.
  always_comb begin
    state_s = state_r;
    y_s     = y_r;
    opb_s   = opb_r;
    prod_s  = prod_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          opb_s  = b;
          prod_s = {{WIDTH{1'b0}}, a};
          cnt_s  = {SH_W{1'b0}};
          op_s   = iter_op_s;
          if (div0_s) begin
            state_s = DONE;
            y_s     = (iter_op_s == OP_DIVU) ? {WIDTH{1'b1}} : a;
          end else if (is_iter_s) begin
            state_s = CALC;
          end else begin
            state_s = DONE;
            y_s     = base_s;
          end
        end else if ((state_r == DONE) && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      CALC: begin
        prod_s = step_s;
        cnt_s  = cnt_r + {{(SH_W-1){1'b0}}, 1'b1};
        if (cnt_r == SH_W'(WIDTH - 1)) begin
          state_s = DONE;
          y_s     = iter_res_s;
        end else begin
          state_s = CALC;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      y_r     <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
      cnt_r   <= {SH_W{1'b0}};
      op_r    <= 2'd0;
    end else begin
      state_r <= state_s;
      y_r     <= y_s;
      opb_r   <= opb_s;
      prod_r  <= prod_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: a transaction-level model (plain
// arithmetic plus a cycle countdown) checked every cycle, plus directed
// vectors with hand-computed results.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, out_ready;
  logic [15:0] f;
  logic [31:0] a, b;
  logic        in_ready, out_valid;
  logic [31:0] y;

  logic        in_valid8, out_ready8;
  logic [15:0] f8;
  logic [7:0]  a8, b8;
  logic        in_ready8, out_valid8;
  logic [7:0]  y8;

  int n_checks = 0;
  int n_fail   = 0;

  iter_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .f(f), .a(a), .b(b), .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );

  iter_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .f(f8), .a(a8), .b(b8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] F_ADD = 16'h0001, F_SUB = 16'h0002, F_SLTU = 16'h0004,
                          F_SLT = 16'h0008, F_AND = 16'h0010, F_OR = 16'h0020,
                          F_NOR = 16'h0040, F_XOR = 16'h0080, F_SLL = 16'h0100,
                          F_SRL = 16'h0200, F_SRA = 16'h0400, F_PASSB = 16'h0800,
                          F_MUL = 16'h1000, F_MULHU = 16'h2000, F_DIVU = 16'h4000,
                          F_REMU = 16'h8000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result for the 32-bit unit, straight from the op definitions.
  function automatic logic [31:0] model(input logic [15:0] ff, input logic [31:0] aa,
                                        input logic [31:0] bb);
    logic [63:0] p;
    p = {32'd0, aa} * {32'd0, bb};
    case (ff)
      F_ADD:   return aa + bb;
      F_SUB:   return aa - bb;
      F_SLTU:  return (aa < bb) ? 32'd1 : 32'd0;
      F_SLT:   return ($signed(aa) < $signed(bb)) ? 32'd1 : 32'd0;
      F_AND:   return aa & bb;
      F_OR:    return aa | bb;
      F_NOR:   return ~(aa | bb);
      F_XOR:   return aa ^ bb;
      F_SLL:   return aa << bb[4:0];
      F_SRL:   return aa >> bb[4:0];
      F_SRA:   return $signed(aa) >>> bb[4:0];
      F_PASSB: return bb;
      F_MUL:   return p[31:0];
      F_MULHU: return p[63:32];
      F_DIVU:  return (bb == 32'd0) ? 32'hFFFF_FFFF : aa / bb;
      F_REMU:  return (bb == 32'd0) ? aa : aa % bb;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit slow_op(input logic [15:0] ff, input logic [31:0] bb);
    if (ff == F_MUL || ff == F_MULHU) return 1'b1;
    if ((ff == F_DIVU || ff == F_REMU) && bb != 32'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Transaction model: m_left counts remaining busy cycles of a slow op.
  logic        m_valid;
  int          m_left;
  logic [31:0] m_y, m_pend;
  logic        m_ready;
  assign m_ready = (m_left == 0 && !m_valid) || (m_valid && out_ready);

  // Advance the model on each clock edge exactly as the handshake rules dictate.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_left  <= 0;
      m_y     <= 32'd0;
      m_pend  <= 32'd0;
    end else if (in_valid && m_ready) begin
      if (slow_op(f, b)) begin
        m_left  <= 32;
        m_valid <= 1'b0;
        m_pend  <= model(f, a, b);
      end else begin
        m_valid <= 1'b1;
        m_y     <= model(f, a, b);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_y     <= m_pend;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Compare the DUT against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_in_ready", in_ready, m_ready);
      check("cyc_out_valid", out_valid, m_valid);
      if (m_valid) check("cyc_y", y, m_y);
    end
  end

  // Issue one op on the 32-bit unit and wait for its result (not consumed).
  task automatic do_op(input logic [15:0] ff, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] exp_y, input int exp_lat, input string nm);
    int lat;
    check({nm, "_ready_before"}, in_ready, 1'b1);
    in_valid = 1'b1; f = ff; a = aa; b = bb; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; f = 16'hFFFF; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (lat == 2) check({nm, "_busy_ready"}, in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_y"}, y, exp_y);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Issue one op on the 8-bit unit, wait for the result and consume it.
  task automatic do_op8(input logic [15:0] ff, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] exp_y, input int exp_lat, input string nm);
    int lat;
    in_valid8 = 1'b1; f8 = ff; a8 = aa; b8 = bb; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
    lat = 1;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_y"}, y8, exp_y);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  typedef struct {
    logic [15:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    int          lat;
  } vec_t;

  vec_t vecs [0:13] = '{
    '{F_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1},
    '{F_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1},
    '{F_OR,    32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1},
    '{F_NOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 1},
    '{F_XOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1},
    '{F_SLL,   32'd1,         32'd31,        32'h8000_0000, 1},
    '{F_SLL,   32'd1,         32'h21,        32'h0000_0002, 1},
    '{F_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 1},
    '{F_PASSB, 32'd9,         32'h1234,      32'h0000_1234, 1},
    '{F_SLT,   32'd5,         32'hFFFF_FFFF, 32'd0,         1},
    '{F_SLTU,  32'd5,         32'hFFFF_FFFF, 32'd1,         1},
    '{F_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 33},
    '{F_REMU,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 33},
    '{F_MULHU, 32'h1234_5678, 32'h10,        32'h0000_0001, 33}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; f = 16'd0; a = 32'd0; b = 32'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; f8 = 16'd0; a8 = 8'd0; b8 = 8'd0;
    #2;
    check("rst_y", y, 32'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_y8", y8, 8'd0);
    check("rst_out_valid8", out_valid8, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the model on a few hand-computed values.
    check("model_add", model(F_ADD, 32'h7FFF_FFFF, 32'd1), 32'h8000_0000);
    check("model_mulhu", model(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("model_divu", model(F_DIVU, 32'd100, 32'd7), 32'd14);
    check("model_sra", model(F_SRA, 32'h8000_0000, 32'd4), 32'hF800_0000);

    // Adder, signed and unsigned compare.
    do_op(F_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, "add"); consume();
    do_op(F_SLT,  32'h8000_0000, 32'd1, 32'd1,         1, "slt"); consume();
    do_op(F_SLTU, 32'h8000_0000, 32'd1, 32'd0,         1, "sltu"); consume();

    // Iterative multiply and divide, including divide by zero.
    do_op(F_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul"); consume();
    do_op(F_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu"); consume();
    do_op(F_REMU, 32'd100, 32'd7, 32'd2,  33, "remu"); consume();
    do_op(F_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_b0"); consume();
    do_op(F_REMU, 32'd5,   32'd0, 32'd5,         1, "remu_b0"); consume();

    // Non-one-hot function selects.
    do_op(16'h0000, 32'd5, 32'd6, 32'd0, 1, "f_zero"); consume();
    do_op(16'h0003, 32'd5, 32'd6, 32'd0, 1, "f_two_bits"); consume();

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat, $sformatf("vec%0d", i));
      consume();
    end

    // Back-pressure: result held, then a new op accepted as the old one leaves.
    do_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_y", y, 32'hFFFF_FFFE);
    end
    out_ready = 1'b1; in_valid = 1'b1; f = F_SRA; a = 32'h8000_0000; b = 32'd4;
    #1;
    check("chain_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("chain_out_valid", out_valid, 1'b1);
    check("chain_y", y, 32'hF800_0000);
    consume();

    // Reset in the middle of a divide.
    in_valid = 1'b1; f = F_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_y", y, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("postrst_in_ready", in_ready, 1'b1);
    do_op(F_ADD, 32'd2, 32'd3, 32'd5, 1, "postrst_add"); consume();

    // Narrow instance: product spills exactly into the high half.
    do_op8(F_MUL,   8'h10, 8'h10, 8'h00, 9, "mul8");
    do_op8(F_MULHU, 8'h10, 8'h10, 8'h01, 9, "mulhu8");
    do_op8(F_DIVU,  8'd200, 8'd9, 8'd22, 9, "divu8");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
